// File: rtl/sd_fifo_wm.sv
// Synchronous srdy/drdy FIFO with occupancy count and programmable almost-full watermark.
// Pointers carry an extra wrap bit so full and empty are told apart without a counter.
module sd_fifo_wm #(
  parameter int width = 16,
  parameter int depth = 4,
  localparam int asz = $clog2(depth)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             c_srdy,
  output logic             c_drdy,
  input  logic [width-1:0] c_data,
  output logic             p_srdy,
  input  logic             p_drdy,
  output logic [width-1:0] p_data,
  input  logic             flush,
  input  logic [asz:0]     af_level,
  output logic [asz:0]     usage,
  output logic             almost_full
);

  localparam logic [asz:0] PtrOne = {{asz{1'b0}}, 1'b1};

  logic [width-1:0] mem_q [depth];
  logic [asz:0]     wr_ptr_q, wr_ptr_d;
  logic [asz:0]     rd_ptr_q, rd_ptr_d;
  logic             empty, full, push, pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[asz-1:0] == rd_ptr_q[asz-1:0]) &&
                 (wr_ptr_q[asz] != rd_ptr_q[asz]);

  // c_drdy is gated by reset so upstream sees no room while reset is held.
  assign c_drdy = reset & ~full & ~flush;
  assign push   = c_srdy & c_drdy;

  assign p_srdy = ~empty;
  assign pop    = p_srdy & p_drdy & ~flush;
  assign p_data = mem_q[rd_ptr_q[asz-1:0]];

  assign usage       = wr_ptr_q - rd_ptr_q;
  assign almost_full = (usage >= af_level);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
    end else if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is deliberately left unreset; p_data is only meaningful with p_srdy.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[asz-1:0]] <= c_data;
    end
  end

endmodule

// File: tb/tb_sd_fifo_wm.sv
// Self-checking bench for sd_fifo_wm: vector table plus a queue model of the FIFO
// contents that predicts handshakes, occupancy, watermark and head data every cycle.
module tb_sd_fifo_wm;

  localparam int Width = 16;
  localparam int Depth = 4;
  localparam int Asz   = 2;

  typedef struct {
    logic             cs;
    logic [Width-1:0] cd;
    logic             pd;
    logic             fl;
    logic [Asz:0]     af;
    logic             expCdrdy;
    logic             expPsrdy;
    logic [Asz:0]     expUsage;
    logic             expAf;
    logic [Width-1:0] expData;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             cSrdy;
  logic             cDrdy;
  logic [Width-1:0] cData;
  logic             pSrdy;
  logic             pDrdy;
  logic [Width-1:0] pData;
  logic             flushIn;
  logic [Asz:0]     afLevel;
  logic [Asz:0]     usage;
  logic             almostFull;

  int checks = 0;
  int errors = 0;
  int popCount = 0;
  logic [Width-1:0] sbQ [$];
  vec_t vecs [10];

  sd_fifo_wm #(.width(Width), .depth(Depth)) dut (
    .clk        (clk),
    .reset      (reset),
    .c_srdy     (cSrdy),
    .c_drdy     (cDrdy),
    .c_data     (cData),
    .p_srdy     (pSrdy),
    .p_drdy     (pDrdy),
    .p_data     (pData),
    .flush      (flushIn),
    .af_level   (afLevel),
    .usage      (usage),
    .almost_full(almostFull)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic applyStimulus(input logic cs, input logic [Width-1:0] cd, input logic pd,
                               input logic fl, input logic [Asz:0] af);
    @(negedge clk);
    cSrdy   = cs;
    cData   = cd;
    pDrdy   = pd;
    flushIn = fl;
    afLevel = af;
    #1;
  endtask

  task automatic checkModel();
    int cnt;
    cnt = sbQ.size();
    checkOutput("c_drdy", 32'(cDrdy), 32'(cnt < Depth && !flushIn && reset));
    checkOutput("p_srdy", 32'(pSrdy), 32'(cnt > 0));
    checkOutput("usage", 32'(usage), 32'(cnt));
    checkOutput("almost_full", 32'(almostFull), 32'(cnt >= int'(afLevel)));
    if (cnt > 0) begin
      checkOutput("p_data", 32'(pData), 32'(sbQ[0]));
    end
  endtask

  task automatic advanceCycle();
    int cnt;
    bit doPush;
    bit doPop;
    cnt    = sbQ.size();
    doPush = cSrdy && (cnt < Depth) && !flushIn;
    doPop  = pDrdy && (cnt > 0) && !flushIn;
    if (reset) begin
      if (flushIn) begin
        sbQ.delete();
      end else begin
        if (doPop) begin
          void'(sbQ.pop_front());
          popCount++;
        end
        if (doPush) begin
          sbQ.push_back(cData);
        end
      end
    end
    @(posedge clk);
  endtask

  task automatic cycle(input logic cs, input logic [Width-1:0] cd, input logic pd,
                       input logic fl, input logic [Asz:0] af);
    applyStimulus(cs, cd, pd, fl, af);
    checkModel();
    advanceCycle();
  endtask

  initial begin
    int streamStart;
    vecs[0] = '{1'b1, 16'h0001, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 3'd0, 1'b0, 16'h0000};
    vecs[1] = '{1'b1, 16'h0002, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 3'd1, 1'b0, 16'h0001};
    vecs[2] = '{1'b1, 16'h0003, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 3'd2, 1'b0, 16'h0001};
    vecs[3] = '{1'b1, 16'h0004, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 3'd3, 1'b1, 16'h0001};
    vecs[4] = '{1'b1, 16'h0005, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 3'd4, 1'b1, 16'h0001};
    vecs[5] = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd3, 1'b0, 1'b1, 3'd4, 1'b1, 16'h0001};
    vecs[6] = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 3'd3, 1'b1, 16'h0002};
    vecs[7] = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 3'd2, 1'b0, 16'h0003};
    vecs[8] = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 3'd1, 1'b0, 16'h0004};
    vecs[9] = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 3'd0, 1'b0, 16'h0000};

    reset   = 1'b0;
    cSrdy   = 1'b0;
    cData   = '0;
    pDrdy   = 1'b0;
    flushIn = 1'b0;
    afLevel = 3'd0;
    #2;
    checkOutput("reset_p_srdy", 32'(pSrdy), 32'd0);
    checkOutput("reset_usage", 32'(usage), 32'd0);
    checkOutput("reset_c_drdy", 32'(cDrdy), 32'd0);
    checkOutput("reset_af_level0", 32'(almostFull), 32'd1);
    afLevel = 3'd3;
    #1;
    checkOutput("reset_af_level3", 32'(almostFull), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Fill to full with the consumer stalled, then drain in order.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].cs, vecs[i].cd, vecs[i].pd, vecs[i].fl, vecs[i].af);
      checkOutput($sformatf("vec%0d_c_drdy", i), 32'(cDrdy), 32'(vecs[i].expCdrdy));
      checkOutput($sformatf("vec%0d_p_srdy", i), 32'(pSrdy), 32'(vecs[i].expPsrdy));
      checkOutput($sformatf("vec%0d_usage", i), 32'(usage), 32'(vecs[i].expUsage));
      checkOutput($sformatf("vec%0d_af", i), 32'(almostFull), 32'(vecs[i].expAf));
      if (vecs[i].expPsrdy) begin
        checkOutput($sformatf("vec%0d_p_data", i), 32'(pData), 32'(vecs[i].expData));
      end
      checkModel();
      advanceCycle();
    end

    // Watermark boundaries at full occupancy.
    for (int i = 0; i < 4; i++) cycle(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0, 3'd3);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 3'd4);
    checkOutput("af_eq_depth", 32'(almostFull), 32'd1);
    afLevel = 3'd5;
    #1;
    checkOutput("af_above_depth", 32'(almostFull), 32'd0);
    afLevel = 3'd7;
    #1;
    checkOutput("af_max_level", 32'(almostFull), 32'd0);
    checkModel();
    advanceCycle();
    for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0000, 1'b1, 1'b0, 3'd3);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 3'd0);
    checkOutput("af_zero_empty", 32'(almostFull), 32'd1);
    checkModel();
    advanceCycle();

    // Continuous stream through many pointer wraps.
    streamStart = popCount;
    for (int i = 0; i <= 256; i++) begin
      cycle(i < 256, 16'(i), 1'b1, 1'b0, 3'd3);
    end
    checkOutput("stream_words_out", 32'(popCount - streamStart), 32'd256);

    // Flush with a concurrent push and pop attempt.
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'h0A00 + 16'(i), 1'b0, 1'b0, 3'd3);
    applyStimulus(1'b1, 16'hDEAD, 1'b1, 1'b1, 3'd3);
    checkOutput("flush_c_drdy", 32'(cDrdy), 32'd0);
    checkModel();
    advanceCycle();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 3'd3);
    checkOutput("flush_usage_next", 32'(usage), 32'd0);
    checkOutput("flush_p_srdy_next", 32'(pSrdy), 32'd0);
    checkModel();
    advanceCycle();
    cycle(1'b1, 16'h1234, 1'b0, 1'b0, 3'd3);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 3'd3);
    checkOutput("post_flush_head", 32'(pData), 32'h1234);
    checkModel();
    advanceCycle();

    // Random handshake traffic with occasional flush and watermark changes.
    for (int i = 0; i < 10000; i++) begin
      cycle(1'($urandom_range(1)), 16'($urandom), 1'($urandom_range(1)),
            ($urandom_range(63) == 0), 3'($urandom_range(7)));
    end
    for (int i = 0; i < 5; i++) cycle(1'b0, 16'h0000, 1'b1, 1'b0, 3'd3);

    // Asynchronous reset with two words stored.
    cycle(1'b1, 16'hAAAA, 1'b0, 1'b0, 3'd3);
    cycle(1'b1, 16'hBBBB, 1'b0, 1'b0, 3'd3);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 3'd3);
    checkOutput("pre_reset_usage", 32'(usage), 32'd2);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_reset_p_srdy", 32'(pSrdy), 32'd0);
    checkOutput("async_reset_usage", 32'(usage), 32'd0);
    checkOutput("async_reset_c_drdy", 32'(cDrdy), 32'd0);
    sbQ.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b1, 16'hBEEF, 1'b0, 1'b0, 3'd3);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 3'd3);
    checkOutput("beef_first_out", 32'(pData), 32'hBEEF);
    checkModel();
    advanceCycle();
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 3'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_fifo_wm.md
Name: sd_fifo_wm

Overview:
- Synchronous srdy/drdy FIFO with an occupancy count and a programmable almost-full watermark.
- It is the producer stage whose c_/p_ interfaces the team's common handshake checker monitors.
- Accepts words on the consumer-side interface and delivers them in order on the producer-side interface.
- Provides a synchronous flush for pipeline abort.

Parameters:
- width, 16: data word width in bits.
- depth, 4: number of storage entries. Must be a power of 2 and at least 2.
- asz, $clog2(depth): pointer index width. Derived; not to be overridden.

Ports:
- clk  input  1  Clock. All state changes on the rising edge.
- reset  input  1  Asynchronous, active-low reset. Asserting it (0) clears all state immediately; release is synchronous to clk.
- c_srdy  input  1  Upstream has a valid word on c_data.
- c_drdy  output  1  FIFO can accept a word this cycle.
- c_data  input  width  Upstream data.
- p_srdy  output  1  FIFO presents a valid word on p_data.
- p_drdy  input  1  Downstream accepts the presented word.
- p_data  output  width  Head-of-FIFO data.
- flush  input  1  Synchronous clear of all stored words.
- af_level  input  asz+1  Almost-full threshold, 0..depth.
- usage  output  asz+1  Current number of stored words, 0..depth.
- almost_full  output  1  High when usage >= af_level.

Behaviour:
- Storage and pointers:
  - Storage is depth x width registers.
  - wr_ptr and rd_ptr are asz+1 bits wide; the MSB is the wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = (index bits equal, wrap bits differ).
  - usage = wr_ptr - rd_ptr, modulo 2^(asz+1).
- Reset (reset == 0, asynchronous):
  - wr_ptr = rd_ptr = 0, so usage = 0.
  - p_srdy = 0, c_drdy = 0 while reset is held, c_drdy = 1 from the first cycle after release.
  - almost_full = (af_level == 0).
  - Storage contents are not reset; p_data is don't-care while p_srdy = 0.
- Push: c_drdy = !full & !flush. On a rising edge with c_srdy & c_drdy:
  - Write c_data at wr_ptr[asz-1:0].
  - wr_ptr increments and wraps naturally.
- Pop:
  - p_srdy = !empty.
  - p_data = mem[rd_ptr[asz-1:0]], a combinational read of registered storage.
  - On p_srdy & p_drdy & !flush, rd_ptr increments.
- Latency: a word pushed in cycle N appears on p_srdy/p_data in cycle N+1 when the FIFO was empty. There is no combinational path from c_srdy to p_srdy.
- Data hold:
  - While p_srdy & !p_drdy and no flush, p_data and p_srdy stay stable.
  - A push into a non-empty FIFO does not alter the head word.
- Simultaneous push and pop:
  - Allowed whenever both handshakes complete; usage is unchanged.
  - When full, c_drdy = 0, so no push occurs; a pop in that cycle makes c_drdy = 1 next cycle.
  - There is no same-cycle fall-through from full.
- Empty: p_srdy = 0, and p_drdy is ignored.
- Wrap-around: correct ordering across index wrap for any number of passes. Equality and full detection rely only on the wrap bit.
- Flush (sampled on the rising edge):
  - rd_ptr is set to wr_ptr, so usage = 0 next cycle.
  - A push in the flush cycle is blocked (c_drdy = 0).
  - A pop handshake in the flush cycle is not counted. p_srdy falls the next cycle, so the downstream must treat the flush cycle as an abort.
  - Verification disables the data-hold and token-count checks across flush.
- Watermark:
  - almost_full is combinational: usage >= af_level, unsigned compare.
  - af_level > depth means almost_full is never asserted.
  - af_level = 0 means almost_full is always asserted.
- Reset mid-operation: all stored words are discarded and outputs take their reset values at once; no partial word emerges after release.
- Ordering invariant: outputs equal inputs in order, and the pushed count minus the popped count equals usage at every cycle.

Test Plan:
- Reset release, then c_srdy = 1 with data 0x0001..0x0004, p_drdy = 0 (depth 4) -> c_drdy falls after the 4th push; usage = 4; p_data = 0x0001 held stable; almost_full = 1 with af_level = 3.
- From full, p_drdy = 1 for 4 cycles, c_srdy = 0 -> p_data sequence 0x0001, 0x0002, 0x0003, 0x0004; p_srdy = 0 on the 5th cycle; usage = 0.
- Continuous stream of 0x0000..0x00FF with c_srdy = p_drdy = 1 -> one word per cycle after 1-cycle initial latency; usage stays at 1; all 256 words exit in order across 64 pointer wraps.
- Fill 3 words, then in one cycle assert flush together with c_srdy = 1 and p_drdy = 1 -> c_drdy = 0 in that cycle; next cycle usage = 0 and p_srdy = 0; the blocked word never appears.
- Random c_srdy/p_drdy toggling over 10k cycles with the checker bound -> no data-hold violation; in_count - out_count == usage; output data matches the history buffer.
- Assert reset = 0 mid-stream with usage = 2 -> p_srdy = 0 and usage = 0 immediately, without waiting for an edge; after release, a pushed 0xBEEF is the first word out.
